pixie_dma_fetch: RTL
====================

Name: pixie_dma_fetch

Overview:
Memory-side DMA engine that sits directly upstream of the pixie video block in the CDP1802 bus clock domain. It services the pixie's DMA-out requests: it takes the address the pixie drives, arbitrates the shared synchronous memory port against CPU reads, and returns each display byte with a one-cycle acknowledge. While DMA owns the port, the CPU is stalled, so display fetches never tear.

Parameters:
RD_LATENCY, 1, memory read latency in clk_enable ticks from mem_rd to valid mem_rdata (legal 1..3)
BURST_LEN, 8, bytes per display line; one burst is the run of transfers while dma_req stays high
ADDR_W, 16, address width

Ports:
clk  in  1  CDP1802 bus clock
reset  in  1  asynchronous, active-low reset
clk_enable  in  1  bus-cycle qualifier; all state advances only when high
dma_req  in  1  DMAO from pixie, level request
dma_addr  in  ADDR_W  byte address driven by pixie (its data_addr)
dma_data  out  8  byte to pixie (its data_in)
dma_ack  out  1  one-tick strobe, dma_data valid (pixie's data_ack)
cpu_addr  in  ADDR_W  CPU read address
cpu_rd  in  1  CPU read request
cpu_rdata  out  8  CPU read data
cpu_stall  out  1  CPU must hold its request
mem_addr  out  ADDR_W  shared memory address
mem_rd  out  1  shared memory read strobe
mem_rdata  in  8  shared memory read data
burst_overrun  out  1  sticky: more than BURST_LEN transfers in one burst

Behaviour:
- Reset (reset low, async): state IDLE; dma_data=0, dma_ack=0, cpu_rdata=0, cpu_stall=0, mem_addr=0, mem_rd=0, burst_overrun=0, burst count=0, latency count=0.
- All transitions and counters are gated by clk_enable. Outputs hold when clk_enable is low. dma_ack and mem_rd are single-tick strobes that clear on the next enabled tick.
- States:
  - IDLE: if dma_req, go to D_ISSUE. Else if cpu_rd, go to C_ISSUE. DMA has priority on a simultaneous request.
  - D_ISSUE: mem_addr<=dma_addr, mem_rd=1, lat<=RD_LATENCY-1, go to D_WAIT.
  - D_WAIT: if lat==0, dma_data<=mem_rdata, dma_ack=1, burst count+1, go to D_GAP. Else lat-1.
  - D_GAP: one tick with dma_ack low. If dma_req is still high, go to D_ISSUE. Else burst count<=0 and go to IDLE.
  - C_ISSUE, C_WAIT: same sequence using cpu_addr. On completion, cpu_rdata<=mem_rdata and return to IDLE.
- Per-request transfer timing: ISSUE to ack = RD_LATENCY+1 ticks. Back-to-back DMA bytes are spaced RD_LATENCY+2 ticks apart.
- cpu_stall=1 whenever the state is not IDLE, and also in IDLE when dma_req=1. It is 0 in IDLE with no dma_req. It clears on the tick a CPU read completes.
- A CPU read already in C_ISSUE/C_WAIT always completes; a DMA request waits until it finishes. Maximum DMA wait is RD_LATENCY+2 ticks.
- If dma_req drops mid-transfer (D_ISSUE/D_WAIT), the byte still completes and is acked. The burst then ends at D_GAP.
- The burst counter is 4 bits wide and saturates at 15. When a transfer completes with count==BURST_LEN already reached, burst_overrun<=1; it stays set until reset.
- dma_addr is sampled only in D_ISSUE, so address changes in other states are ignored.
- Reset mid-transfer aborts immediately. No ack is issued, and the memory strobe drops asynchronously.

Test Plan:
- Reset, then dma_req=1 with dma_addr=0x0900 and mem_rdata=0x5A (RD_LATENCY=1) -> mem_rd at tick 1, dma_ack with dma_data=0x5A at tick 2, cpu_stall=1 throughout.
- Burst of 8 transfers, addresses 0x0900..0x0907, dma_req dropped after the 8th ack -> 8 acks spaced 3 ticks apart, return to IDLE, burst_overrun=0. A 9th transfer in the same burst -> burst_overrun=1.
- cpu_rd and dma_req rise on the same tick -> DMA is served first. CPU read of 0x0123 completes after dma_req drops, and cpu_rdata equals memory content.
- CPU read in C_WAIT when dma_req rises -> CPU completes, then D_ISSUE on the next enabled tick, with no lost ack.
- clk_enable toggling 1-0-1-0 during a transfer -> identical ack/data sequence, stretched by 2x; no duplicate strobes.
- Async reset asserted during D_WAIT -> all outputs are 0 immediately. After release, IDLE accepts a new request normally.

Source files
------------

// File: rtl/pixie_dma_fetch.sv
// pixie_dma_fetch: arbitrates one shared synchronous memory read port
// between pixie display DMA (priority) and CPU reads. DMA bytes come back
// with a one-tick acknowledge. The CPU is stalled while DMA owns the port.
module pixie_dma_fetch #(
  parameter int unsigned RD_LATENCY = 1,  // 1..3 clk_enable ticks
  parameter int unsigned BURST_LEN  = 8,  // bytes per display line
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active-low
  input  logic              clk_enable,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic [7:0]        dma_data,
  output logic              dma_ack,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              burst_overrun
);

  typedef enum logic [2:0] {
    IDLE, D_ISSUE, D_WAIT, D_GAP, C_ISSUE, C_WAIT
  } state_t;

  localparam logic [1:0] LAT_INIT  = 2'(RD_LATENCY - 1);
  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_t            state, state_next;
  logic [1:0]        lat, lat_next;
  logic [3:0]        burst_cnt, burst_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic              mem_rd_next;
  logic [7:0]        dma_data_next;
  logic              dma_ack_next;
  logic [7:0]        cpu_rdata_next;
  logic              overrun_next;

  // Next-state and next-register values for the arbiter.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    lat_next       = lat;
    burst_next     = burst_cnt;
    mem_addr_next  = mem_addr;
    mem_rd_next    = 1'b0;     // strobe: high for one enabled tick only
    dma_data_next  = dma_data;
    dma_ack_next   = 1'b0;     // strobe: high for one enabled tick only
    cpu_rdata_next = cpu_rdata;
    overrun_next   = burst_overrun;

    unique case (state)
      IDLE: begin
        // DMA wins a simultaneous request so display fetches never tear.
        if (dma_req)     state_next = D_ISSUE;
        else if (cpu_rd) state_next = C_ISSUE;
      end
      D_ISSUE: begin
        mem_addr_next = dma_addr;   // only place dma_addr is sampled
        mem_rd_next   = 1'b1;
        lat_next      = LAT_INIT;
        state_next    = D_WAIT;
      end
      D_WAIT: begin
        if (lat == 2'd0) begin
          dma_data_next = mem_rdata;
          dma_ack_next  = 1'b1;
          if (burst_cnt >= BURST_MAX) overrun_next = 1'b1;
          if (burst_cnt != 4'hF)      burst_next   = burst_cnt + 4'd1;
          state_next = D_GAP;
        end else begin
          lat_next = lat - 2'd1;
        end
      end
      D_GAP: begin
        // Quiet tick between bytes; a dropped request ends the burst here.
        if (dma_req) begin
          state_next = D_ISSUE;
        end else begin
          burst_next = 4'd0;
          state_next = IDLE;
        end
      end
      C_ISSUE: begin
        mem_addr_next = cpu_addr;
        mem_rd_next   = 1'b1;
        lat_next      = LAT_INIT;
        state_next    = C_WAIT;
      end
      C_WAIT: begin
        // A started CPU read always completes before DMA is granted.
        if (lat == 2'd0) begin
          cpu_rdata_next = mem_rdata;
          state_next     = IDLE;
        end else begin
          lat_next = lat - 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; everything holds while clk_enable is low.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lat           <= 2'd0;
      burst_cnt     <= 4'd0;
      mem_addr      <= '0;
      mem_rd        <= 1'b0;
      dma_data      <= 8'd0;
      dma_ack       <= 1'b0;
      cpu_rdata     <= 8'd0;
      burst_overrun <= 1'b0;
    end else if (clk_enable) begin
      state         <= state_next;
      lat           <= lat_next;
      burst_cnt     <= burst_next;
      mem_addr      <= mem_addr_next;
      mem_rd        <= mem_rd_next;
      dma_data      <= dma_data_next;
      dma_ack       <= dma_ack_next;
      cpu_rdata     <= cpu_rdata_next;
      burst_overrun <= overrun_next;
    end
  end

  // Stall whenever the port is busy or DMA is about to take it; forced low
  // during reset even if the pixie keeps requesting.
  assign cpu_stall = reset & ((state != IDLE) | dma_req);

endmodule
